alu_arb: RTL
============

ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have ports req0 / req1, input, 1 bit each: level request from requester 0 / 1, held until granted.
REQ-004 SHALL have ports a0, b0 / a1, b1, input, 4 bits each: operands of requester 0 / 1.
REQ-005 SHALL have ports op0 / op1, input, 3 bits each: ALU opcode of requester 0 / 1.
REQ-006 SHALL have ports gnt0 / gnt1, output, 1 bit each: one-cycle grant pulse; the request and operands are captured.
REQ-007 SHALL have ports alu_a, alu_b, output, 4 bits each, and alu_opt, output, 3 bits: registered operands and opcode driving the shared ALU.
REQ-008 SHALL have port alu_out, input, 4 bits, and ports alu_carry, alu_overflow, alu_sign, alu_zero, alu_parity, input, 1 bit each: ALU result and flags.
REQ-009 SHALL have port res, output, 4 bits, and port flags, output, 5 bits: captured result; flags = {carry, overflow, sign, zero, parity}.
REQ-010 SHALL have ports done0 / done1, output, 1 bit each: one-cycle pulse; res/flags valid for that requester.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state != IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, DONE; transitions IDLE->EXEC on grant, EXEC->DONE unconditionally, DONE->IDLE unconditionally.
REQ-013 SHALL sample req0/req1 only at a rising edge while in IDLE; requests in EXEC/DONE are ignored, not queued.
REQ-014 SHALL, on a grant at edge N, load alu_a/alu_b/alu_opt from the winner's a/b/op, assert the winner's gnt for cycle N..N+1, and enter EXEC.
REQ-015 SHALL, at edge N+1 (end of EXEC), register alu_out and flags into res/flags, pulse the winner's done for cycle N+1..N+2, and enter DONE.
REQ-016 SHALL return to IDLE at edge N+2; next grant earliest at edge N+3; max throughput one op per 3 cycles.
REQ-017 SHALL arbitrate round-robin: single requester wins; both requesting -> the requester not served last wins; last-served pointer updates on every grant.
REQ-018 SHALL hold alu_a/alu_b/alu_opt stable from grant until the next grant.
REQ-019 SHALL hold res/flags stable from capture until the next capture.
REQ-020 SHALL never assert gnt0 and gnt1 together, nor done0 and done1 together.
REQ-021 SHALL pass opcodes through unmodified; the ALU encoding is not interpreted.

Reset
REQ-022 SHALL, while rst=1, force state IDLE; gnt0, gnt1, done0, done1, busy = 0; alu_a, alu_b, res = 0; alu_opt = 0; flags = 0; last-served pointer = 1, so req0 wins the first tie.
REQ-023 SHALL abort any in-flight operation on rst asserted mid-EXEC/DONE: no done pulse, and res keeps its reset value.

Verification
REQ-024 SHALL pass: single req0, a0=5, b0=11, op0=0, stub ALU alu_out = a+b -> gnt0 at cycle 1, alu_a=5, alu_b=11, done0 at cycle 2, res=0, carry=1 per stub.
REQ-025 SHALL pass: req0 and req1 both held high from reset -> grant order 0,1,0,1; gnt spacing exactly 3 cycles; no double grants.
REQ-026 SHALL pass: req1 alone twice in a row -> both granted to requester 1; the pointer does not block a lone requester.
REQ-027 SHALL pass: req0 asserted during EXEC of a requester-1 op -> not granted until the first IDLE edge after done1.
REQ-028 SHALL pass: rst pulsed in EXEC -> busy=0 and res=0 immediately; no done pulse; next req0 served normally.
REQ-029 SHALL pass: all eight op codes 000-111 issued via requester 0 -> alu_opt matches each op code, and res/flags equal the stub ALU outputs.

Source files
------------

// File: rtl/alu_arb.sv
// Two-requester round-robin front end for a shared, externally supplied ALU.
// Each granted operation spends one cycle in EXEC, captures the result, then one cycle in DONE.
module alu_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_opt,
  input  logic [3:0] alu_out,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       alu_sign,
  input  logic       alu_zero,
  input  logic       alu_parity,
  output logic [3:0] res,
  output logic [4:0] flags,
  output logic       done0,
  output logic       done1,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state, state_nx;
  logic   last;   // requester served most recently (1 after reset, so req0 wins the first tie)
  logic   owner;  // requester of the operation in flight
  logic   grant;
  logic   pick;   // 1 selects requester 1

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    pick     = 1'b0;
    case (state)
      IDLE: if (req0 || req1) begin
        grant    = 1'b1;
        // A lone requester always wins; on a tie the one not served last wins.
        pick     = req1 && (!req0 || !last);
        state_nx = EXEC;
      end
      EXEC:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_opt <= '0;
      res     <= '0;
      flags   <= '0;
      last    <= 1'b1;
      owner   <= 1'b0;
    end else begin
      gnt0  <= grant && !pick;
      gnt1  <= grant && pick;
      done0 <= (state == EXEC) && !owner;
      done1 <= (state == EXEC) && owner;
      if (grant) begin
        alu_a   <= pick ? a1  : a0;
        alu_b   <= pick ? b1  : b0;
        alu_opt <= pick ? op1 : op0;
        last    <= pick;
        owner   <= pick;
      end
      if (state == EXEC) begin
        res   <= alu_out;
        flags <= {alu_carry, alu_overflow, alu_sign, alu_zero, alu_parity};
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
